stereo_mpx_decoder: RTL and testbench

//  Receive-side counterpart of the stereo MPX encoder: recovers L/R audio from an MPX sample stream.
//  A pilot PLL locks a local NCO to the 19 kHz pilot. The NCO's doubled phase gives the 38 kHz sign reference.

---
 rtl/stereo_mpx_decoder_pkg.sv | 34 +++
 rtl/stereo_mpx_decoder_pilot_pll.sv | 156 +++++++++++++++
 rtl/stereo_mpx_decoder.sv | 120 ++++++++++++
 tb/tb_stereo_mpx_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_mpx_decoder_pkg.sv
// Shared widths, lock state encoding and signed saturation helpers for the MPX decoder.
// Combinational helpers only; no latency, no flow control.
package stereo_mpx_decoder_pkg;

  localparam int IN_WIDTH_DEF    = 16;
  localparam int PHASE_WIDTH_DEF = 32;
  localparam int DECIM_LOG2_DEF  = 4;
  localparam int ACC_WIDTH_DEF   = IN_WIDTH_DEF + DECIM_LOG2_DEF + 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int acc_width(input int in_w, input int decim_log2);
    return in_w + decim_log2 + 2;
  endfunction

  function automatic logic signed [63:0] sat_range(input logic signed [63:0] v,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Clamp to the two's-complement range of a w-bit signed value.
  function automatic logic signed [63:0] sat_bits(input logic signed [63:0] v, input int w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return sat_range(v, -lim, lim - 64'sd1);
  endfunction

endpackage

// File: rtl/stereo_mpx_decoder_pilot_pll.sv
// Pilot PLL: NCO, cos/sin correlators, PI loop filter and lock FSM; updates once per dump.
// Dump strobe is combinational on the final sample; loop/lock results land 1 cycle later. No backpressure.
module pilot_pll
  import stereo_mpx_decoder_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int DECIM_LOG2  = DECIM_LOG2_DEF,
  parameter int KP_SHIFT    = 6,
  parameter int KI_SHIFT    = 12,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                           mclk,
  input  logic                           mreset_n,
  input  logic                           enable_i,
  input  logic                           mpx_valid_i,
  input  logic [PHASE_WIDTH-1:0]         step_nom_i,
  input  logic [IN_WIDTH+DECIM_LOG2-1:0] lock_thresh_i,
  input  logic [IN_WIDTH-1:0]            mpx_in_i,
  output logic [PHASE_WIDTH-1:0]         phase_o,
  output logic                           dump_o,
  output logic                           locked_o,
  output logic [PHASE_WIDTH-1:0]         freq_adj_o
);

  localparam int ACC_W = acc_width(IN_WIDTH, DECIM_LOG2);
  localparam int LCW   = $clog2(LOCK_COUNT + 1);
  localparam logic signed [63:0] FA_LIM = 64'sd1 <<< (PHASE_WIDTH - 8);

  logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]  freq_adj_q, freq_adj_d;
  logic signed [ACC_W-1:0] p_term_q, p_term_d;
  logic signed [ACC_W-1:0] err_acc_q, err_acc_d;
  logic signed [ACC_W-1:0] i_acc_q, i_acc_d;
  logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
  lock_state_t             state_q;
  logic [LCW-1:0]          lock_cnt_q;
  logic                    locked_q;

  logic                    accept, dump;
  logic                    q_ref, i_ref, thresh_met;
  logic signed [ACC_W-1:0] x_ext, err_sum, i_sum, err_ki;
  logic [PHASE_WIDTH-1:0]  phase_next;
  logic signed [63:0]      fa_sum;

  assign accept = mpx_valid_i & enable_i;
  assign dump   = accept & (cnt_q == {DECIM_LOG2{1'b1}});
  assign x_ext  = ACC_W'($signed(mpx_in_i));

  // Quadrant signs of the pre-update phase: cos sign drives the loop, sin sign measures lock.
  assign q_ref = phase_q[PHASE_WIDTH-1] ^ phase_q[PHASE_WIDTH-2];
  assign i_ref = phase_q[PHASE_WIDTH-1];

  assign err_sum    = err_acc_q + (q_ref ? -x_ext : x_ext);
  assign i_sum      = i_acc_q + (i_ref ? -x_ext : x_ext);
  assign err_ki     = err_sum >>> KI_SHIFT;
  assign phase_next = phase_q + step_nom_i + freq_adj_q + PHASE_WIDTH'(p_term_q);
  assign fa_sum     = 64'($signed(freq_adj_q)) + 64'(err_ki);
  assign thresh_met = i_sum >= $signed({2'b00, lock_thresh_i});

  always_comb begin
    phase_d    = phase_q;
    freq_adj_d = freq_adj_q;
    p_term_d   = p_term_q;
    err_acc_d  = err_acc_q;
    i_acc_d    = i_acc_q;
    cnt_d      = cnt_q;
    if (!enable_i) begin
      phase_d    = '0;
      freq_adj_d = '0;
      p_term_d   = '0;
      err_acc_d  = '0;
      i_acc_d    = '0;
      cnt_d      = '0;
    end else if (accept) begin
      phase_d = phase_next;
      cnt_d   = cnt_q + DECIM_LOG2'(1);
      if (dump) begin
        err_acc_d  = '0;
        i_acc_d    = '0;
        p_term_d   = err_sum >>> KP_SHIFT;
        freq_adj_d = PHASE_WIDTH'(sat_range(fa_sum, -FA_LIM, FA_LIM));
      end else begin
        err_acc_d = err_sum;
        i_acc_d   = i_sum;
      end
    end
  end

  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      phase_q    <= '0;
      freq_adj_q <= '0;
      p_term_q   <= '0;
      err_acc_q  <= '0;
      i_acc_q    <= '0;
      cnt_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      freq_adj_q <= freq_adj_d;
      p_term_q   <= p_term_d;
      err_acc_q  <= err_acc_d;
      i_acc_q    <= i_acc_d;
      cnt_q      <= cnt_d;
    end
  end

  // A dump agreeing with the pending direction advances the run; any other dump restarts it.
  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (!enable_i) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (dump) begin
      case (state_q)
        UNLOCKED: begin
          if (!thresh_met) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LCW'(LOCK_COUNT - 1)) begin
            state_q    <= LOCKED;
            lock_cnt_q <= '0;
            locked_q   <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        LOCKED: begin
          if (thresh_met) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LCW'(LOCK_COUNT - 1)) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        default: begin
          state_q    <= UNLOCKED;
          lock_cnt_q <= '0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  assign phase_o    = phase_q;
  assign dump_o     = dump;
  assign locked_o   = locked_q;
  assign freq_adj_o = freq_adj_q;

endmodule

// File: rtl/stereo_mpx_decoder.sv
// Stereo MPX decoder: pilot PLL plus sum/difference accumulate-and-dump and L/R matrix.
// L/R and out_valid are registered 1 cycle after the dumping sample; no backpressure, sink takes every strobe.
module stereo_mpx_decoder
  import stereo_mpx_decoder_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int DECIM_LOG2  = DECIM_LOG2_DEF,
  parameter int KP_SHIFT    = 6,
  parameter int KI_SHIFT    = 12,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                           mclk,
  input  logic                           mreset_n,
  input  logic                           enable,
  input  logic [PHASE_WIDTH-1:0]         step_nom,
  input  logic [IN_WIDTH+DECIM_LOG2-1:0] lock_thresh,
  input  logic [IN_WIDTH-1:0]            mpx_in,
  input  logic                           mpx_valid,
  output logic [IN_WIDTH-1:0]            l_out,
  output logic [IN_WIDTH-1:0]            r_out,
  output logic                           out_valid,
  output logic                           locked,
  output logic [PHASE_WIDTH-1:0]         freq_adj
);

  localparam int ACC_W = acc_width(IN_WIDTH, DECIM_LOG2);
  localparam int SUM_W = ACC_W + 1;

  logic [PHASE_WIDTH-1:0]  nco_phase;
  logic                    dump, pll_locked;
  logic                    accept, s38;
  logic                    unused_phase_bits;

  logic signed [ACC_W-1:0] sum_acc_q, sum_acc_d;
  logic signed [ACC_W-1:0] diff_acc_q, diff_acc_d;
  logic [IN_WIDTH-1:0]     l_q, l_d, r_q, r_d;
  logic                    vld_q, vld_d;

  logic signed [ACC_W-1:0] x_ext, sum_sum, diff_sum, d_sel;
  logic signed [SUM_W-1:0] l_wide, r_wide;

  pilot_pll #(
    .IN_WIDTH    (IN_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .DECIM_LOG2  (DECIM_LOG2),
    .KP_SHIFT    (KP_SHIFT),
    .KI_SHIFT    (KI_SHIFT),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_pll (
    .mclk          (mclk),
    .mreset_n      (mreset_n),
    .enable_i      (enable),
    .mpx_valid_i   (mpx_valid),
    .step_nom_i    (step_nom),
    .lock_thresh_i (lock_thresh),
    .mpx_in_i      (mpx_in),
    .phase_o       (nco_phase),
    .dump_o        (dump),
    .locked_o      (pll_locked),
    .freq_adj_o    (freq_adj)
  );

  // Doubled-phase MSB: sign of the 38 kHz subcarrier.
  assign s38               = nco_phase[PHASE_WIDTH-2];
  assign unused_phase_bits = ^{nco_phase[PHASE_WIDTH-1], nco_phase[PHASE_WIDTH-3:0]};

  assign accept   = mpx_valid & enable;
  assign x_ext    = ACC_W'($signed(mpx_in));
  assign sum_sum  = sum_acc_q + x_ext;
  assign diff_sum = diff_acc_q + (s38 ? -x_ext : x_ext);
  assign d_sel    = pll_locked ? diff_sum : '0;
  assign l_wide   = SUM_W'(sum_sum) + SUM_W'(d_sel);
  assign r_wide   = SUM_W'(sum_sum) - SUM_W'(d_sel);

  always_comb begin
    sum_acc_d  = sum_acc_q;
    diff_acc_d = diff_acc_q;
    l_d        = l_q;
    r_d        = r_q;
    vld_d      = 1'b0;
    if (!enable) begin
      sum_acc_d  = '0;
      diff_acc_d = '0;
    end else if (accept) begin
      if (dump) begin
        sum_acc_d  = '0;
        diff_acc_d = '0;
        l_d        = IN_WIDTH'(sat_bits(64'(l_wide >>> DECIM_LOG2), IN_WIDTH));
        r_d        = IN_WIDTH'(sat_bits(64'(r_wide >>> DECIM_LOG2), IN_WIDTH));
        vld_d      = 1'b1;
      end else begin
        sum_acc_d  = sum_sum;
        diff_acc_d = diff_sum;
      end
    end
  end

  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      sum_acc_q  <= '0;
      diff_acc_q <= '0;
      l_q        <= '0;
      r_q        <= '0;
      vld_q      <= 1'b0;
    end else begin
      sum_acc_q  <= sum_acc_d;
      diff_acc_q <= diff_acc_d;
      l_q        <= l_d;
      r_q        <= r_d;
      vld_q      <= vld_d;
    end
  end

  assign l_out     = l_q;
  assign r_out     = r_q;
  assign out_valid = vld_q;
  assign locked    = pll_locked;

endmodule

// File: tb/tb_stereo_mpx_decoder.sv
// Directed and randomized bench for stereo_mpx_decoder against a per-sample arithmetic model.
module tb_stereo_mpx_decoder;

  logic        mclk = 1'b0;
  logic        mreset_n;
  logic        enable;
  logic [31:0] step_nom;
  logic [19:0] lock_thresh;
  logic [15:0] mpx_in;
  logic        mpx_valid;
  logic [15:0] l_out, r_out;
  logic        out_valid, locked;
  logic [31:0] freq_adj;

  always #5 mclk = ~mclk;

  stereo_mpx_decoder dut (
    .mclk        (mclk),
    .mreset_n    (mreset_n),
    .enable      (enable),
    .step_nom    (step_nom),
    .lock_thresh (lock_thresh),
    .mpx_in      (mpx_in),
    .mpx_valid   (mpx_valid),
    .l_out       (l_out),
    .r_out       (r_out),
    .out_valid   (out_valid),
    .locked      (locked),
    .freq_adj    (freq_adj)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pil[16];
  int sq_amp;

  // Reference model state: phase as an integer in [0, 2^32), everything else plain integers.
  localparam longint P32 = 64'sh1_0000_0000;
  longint m_phase, m_fa, m_p, m_err, m_i, m_sum, m_diff, m_l, m_r;
  int     m_cnt, m_lcnt, n_smp;
  bit     m_locked, m_vld;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear_loop();
    m_phase = 0; m_fa = 0; m_p = 0; m_err = 0; m_i = 0; m_sum = 0; m_diff = 0;
    m_cnt = 0; m_lcnt = 0; m_locked = 0; n_smp = 0; m_vld = 0;
  endtask

  task automatic model_reset();
    model_clear_loop();
    m_l = 0; m_r = 0;
  endtask

  task automatic model_step(input bit en, input bit vld, input int x);
    longint quad, t, dsel;
    bit in_phase_neg, cos_neg, sub_neg, above;
    m_vld = 0;
    if (!en) begin
      model_clear_loop();
      return;
    end
    if (!vld) return;
    quad         = m_phase / 64'd1073741824;
    cos_neg      = (quad == 1) || (quad == 2);
    in_phase_neg = (quad >= 2);
    sub_neg      = (quad == 1) || (quad == 3);
    m_err  += cos_neg ? -x : x;
    m_i    += in_phase_neg ? -x : x;
    m_sum  += x;
    m_diff += sub_neg ? -x : x;
    t = (m_phase + longint'(step_nom) + m_fa + m_p) % P32;
    if (t < 0) t += P32;
    m_phase = t;
    n_smp++;
    m_cnt++;
    if (m_cnt == 16) begin
      dsel = m_locked ? m_diff : 0;
      m_l  = clamp(fdiv(m_sum + dsel, 16), -32768, 32767);
      m_r  = clamp(fdiv(m_sum - dsel, 16), -32768, 32767);
      m_p  = fdiv(m_err, 64);
      m_fa = clamp(m_fa + fdiv(m_err, 4096), -(64'sd1 << 24), 64'sd1 << 24);
      above = (m_i >= longint'(lock_thresh));
      if (above != m_locked) begin
        m_lcnt++;
        if (m_lcnt == 8) begin
          m_locked = above;
          m_lcnt   = 0;
        end
      end else begin
        m_lcnt = 0;
      end
      m_err = 0; m_i = 0; m_sum = 0; m_diff = 0; m_cnt = 0;
      m_vld = 1;
    end
  endtask

  task automatic cycle(input bit en, input bit vld, input int x);
    enable    = en;
    mpx_valid = vld;
    mpx_in    = x[15:0];
    @(posedge mclk);
    model_step(en, vld, x);
    #1;
    chk("out_valid", out_valid, m_vld);
    chk("locked", locked, m_locked);
    chk("l_out", $signed(l_out), m_l);
    chk("r_out", $signed(r_out), m_r);
    chk("freq_adj", $signed(freq_adj), m_fa);
  endtask

  // mode 0: pilot, 1: pilot + subcarrier square, 2: square only, 3: full-scale aligned with s38=0
  function automatic int sample(input int mode, input int n);
    int sq;
    sq = ((n % 8) < 4) ? sq_amp : -sq_amp;
    case (mode)
      0:       return pil[n % 16];
      1:       return pil[n % 16] + sq;
      2:       return sq;
      default: return ((n % 8) < 4) ? 32767 : 0;
    endcase
  endfunction

  task automatic run_dump(input int mode);
    for (int k = 0; k < 16; k++) cycle(1'b1, 1'b1, sample(mode, n_smp));
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) pil[k] = int'(4096.0 * $sin(2.0 * 3.14159265358979 * (k + 0.5) / 16.0));
    sq_amp      = 2000;
    mreset_n    = 1'b0;
    enable      = 1'b0;
    mpx_valid   = 1'b0;
    mpx_in      = '0;
    step_nom    = 32'h1000_0000;
    lock_thresh = 20'd4000;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    mreset_n = 1'b1;

    // Random stream, then reset asserted mid-dump between clock edges.
    for (int k = 0; k < 21; k++) cycle(1'b1, 1'($urandom_range(0, 1)), rnd16());
    #2;
    mreset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_l_out", $signed(l_out), 0);
    chk("rst_r_out", $signed(r_out), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_freq_adj", $signed(freq_adj), 0);
    @(posedge mclk);
    #1;
    mreset_n = 1'b1;

    // First dump after release: 16 valid samples then one cycle.
    for (int k = 0; k < 15; k++) cycle(1'b1, 1'b1, 1000);
    chk("no_early_dump", out_valid, 0);
    cycle(1'b1, 1'b1, 1000);
    chk("first_dump_valid", out_valid, 1);
    chk("const_l", $signed(l_out), 1000);

    // Constant input, no pilot: mono 1000 and never locked.
    for (int k = 0; k < 112; k++) cycle(1'b1, 1'b1, 1000);
    chk("const_l_end", $signed(l_out), 1000);
    chk("const_r_end", $signed(r_out), 1000);
    chk("const_unlocked", locked, 0);

    // Randomized stretch: gaps, full-range data, occasional enable drops.
    lock_thresh = 20'($urandom_range(0, 3000));
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 2) != 0), rnd16());

    // Pilot at nominal frequency: lock after exactly 8 dumps.
    cycle(1'b0, 1'b0, 0);
    lock_thresh = 20'd20000;
    for (int d = 1; d <= 8; d++) begin
      run_dump(0);
      if (d == 7) chk("lock_not_yet", locked, 0);
    end
    chk("lock_after_8", locked, 1);
    chk("fa_bounded", ($signed(freq_adj) <= 4096) && ($signed(freq_adj) >= -4096), 1);

    // Stereo difference carried on the subcarrier.
    sq_amp = int'($urandom_range(1500, 2500));
    for (int d = 0; d < 3; d++) begin
      run_dump(1);
      chk("stereo_l_near", ($signed(l_out) - sq_amp <= 64) && (sq_amp - $signed(l_out) <= 64), 1);
      chk("stereo_r_near", ($signed(r_out) + sq_amp <= 64) && (-sq_amp - $signed(r_out) <= 64), 1);
    end

    // Pilot removed: unlock after exactly 8 dumps, then mono.
    for (int d = 1; d <= 8; d++) begin
      run_dump(2);
      if (d == 7) chk("unlock_not_yet", locked, 1);
    end
    chk("unlock_after_8", locked, 0);
    run_dump(2);
    chk("mono_after_unlock", l_out == r_out, 1);

    // Relock, then full-scale aligned diff; finally drop enable.
    for (int d = 0; d < 8; d++) run_dump(0);
    chk("relock", locked, 1);
    run_dump(3);
    chk("fs_l_out", $signed(l_out), 32767);
    chk("fs_r_out", $signed(r_out), 0);
    cycle(1'b0, 1'b1, 5);
    chk("disable_unlock", locked, 0);
    chk("disable_hold_l", $signed(l_out), 32767);
    chk("disable_no_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
